// File: rtl/instruction_prefetch_buffer.sv
// Instruction prefetch buffer: owns the fetch PC, issues word reads over a
// req/ack bus, queues returned words with their addresses and hands the head
// entry to the decoder. A flush empties the queue and restarts fetching at the
// flush target; a request already on the bus is completed and its data dropped.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no request outstanding; may issue one this cycle if room
// WAIT_ACK | request at fetch_pc outstanding, data will be queued
// DISCARD  | pre-flush request outstanding at discard_addr, data dropped
module instruction_prefetch_buffer #(
   parameter int          DEPTH        = 2,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        flush,
   input  logic [31:0] flush_addr,
   input  logic        decode_ready,
   output logic [31:0] instruction,
   output logic        instruction_valid,
   output logic [31:0] instruction_pc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // one spare bit so occupancy + 1 never wraps
   localparam int CW = $clog2(DEPTH + 1) + 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      DISCARD  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [31:0]     fetch_pc;
   logic [31:0]     discard_addr;
   logic [31:0]     flush_target;
   logic [31:0]     fifo_instr [DEPTH];
   logic [31:0]     fifo_pc    [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   occ_hold;
   logic [CW-1:0]   occ_push;
   logic            space_hold;
   logic            space_push;
   logic            req_int;
   logic            accept;
   logic            push;
   logic            pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign flush_target = flush_addr & 32'hFFFF_FFFC;

   assign instruction_valid = !reset && (count != '0);
   assign instruction       = instruction_valid ? fifo_instr[rd_ptr] : '0;
   assign instruction_pc    = instruction_valid ? fifo_pc[rd_ptr]    : '0;
   assign pop               = instruction_valid && decode_ready;

   // occupancy after this cycle's pop, without and with a push
   assign occ_hold   = count - CW'(pop);
   assign occ_push   = occ_hold + CW'(1);
   assign space_hold = occ_hold < CW'(DEPTH);
   assign space_push = occ_push < CW'(DEPTH);

   assign mem_req  = !reset && req_int;
   assign mem_addr = reset ? RESET_VECTOR :
                     (state == DISCARD) ? discard_addr : fetch_pc;
   assign push     = accept && (state != DISCARD) && !flush;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // request generation and next-state selection
   always_comb begin
      state_n = state;
      req_int = 1'b0;
      case (state)
         IDLE:              req_int = space_hold;
         WAIT_ACK, DISCARD: req_int = 1'b1;
         default:           req_int = 1'b0;
      endcase
      accept = !reset && req_int && mem_ack;
      case (state)
         IDLE, WAIT_ACK: begin
            if (accept)       state_n = space_push ? WAIT_ACK : IDLE;
            else if (req_int) state_n = WAIT_ACK;
         end
         DISCARD: begin
            if (accept) state_n = space_hold ? WAIT_ACK : IDLE;
         end
         default: state_n = IDLE;
      endcase
      // the bus cannot be aborted, so an unacked request is finished in DISCARD
      if (flush) state_n = (req_int && !mem_ack) ? DISCARD : WAIT_ACK;
   end

   // fetch PC and the address held for a request being discarded
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc     <= RESET_VECTOR;
         discard_addr <= RESET_VECTOR;
      end else if (flush) begin
         fetch_pc <= flush_target;
         if (mem_req && !mem_ack) discard_addr <= mem_addr;
      end else if (push) begin
         fetch_pc <= fetch_pc + 32'd4;
      end
   end

   // queue pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // queue storage; contents are only visible through the valid-gated outputs
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= mem_rdata;
         fifo_pc[wr_ptr]    <= fetch_pc;
      end
   end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Bench for instruction_prefetch_buffer: a bus-level memory model issues acks
// and records the words the decoder should receive; a monitor compares the
// decoder-side outputs against that expected stream.
module tb_instruction_prefetch_buffer;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RV    = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        flush;
   logic [31:0] flush_addr;
   logic        decode_ready;
   logic [31:0] instruction;
   logic        instruction_valid;
   logic [31:0] instruction_pc;

   instruction_prefetch_buffer #(.DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
      .clk               (clk),
      .reset             (reset),
      .mem_req           (mem_req),
      .mem_addr          (mem_addr),
      .mem_ack           (mem_ack),
      .mem_rdata         (mem_rdata),
      .flush             (flush),
      .flush_addr        (flush_addr),
      .decode_ready      (decode_ready),
      .instruction       (instruction),
      .instruction_valid (instruction_valid),
      .instruction_pc    (instruction_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      int          cyc;
   } ent_t;

   ent_t        exp_q[$];
   logic [31:0] popped_pcs[$];
   int          checks = 0;
   int          failures = 0;
   int          pops = 0;
   int          cyc_now = 0;

   // fetch model: next live address, and a pre-flush request still on the bus
   logic [31:0] exp_pc = RV;
   logic [31:0] drop_addr = RV;
   logic        drop_pending = 1'b0;
   logic [31:0] key = 32'h0;
   int          wait_cnt = 0;
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic [31:0] prev_addr = RV;

   always @(posedge clk) cyc_now <= cyc_now + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // one clock of stimulus; mode: 0 no ack, 1 zero-wait, 2 random, 3 three wait cycles
   task automatic step(input bit rst, input bit rdy, input bit fl,
                       input logic [31:0] fa, input int mode);
      bit          a;
      logic [31:0] exp_a;
      @(posedge clk);
      #1;
      reset        = rst;
      decode_ready = rdy;
      flush        = fl;
      flush_addr   = fa;
      mem_ack      = 1'b0;
      #1;
      if (rst) begin
         exp_pc       = RV;
         drop_pending = 1'b0;
         wait_cnt     = 0;
         mem_rdata    = $urandom;
         prev_req     = 1'b0;
         prev_ack     = 1'b0;
      end else begin
         if (prev_req && !prev_ack) begin
            chk("req_hold", 32'(mem_req), 32'd1);
            chk("addr_hold", mem_addr, prev_addr);
         end
         case (mode)
            0:       a = 1'b0;
            1:       a = 1'b1;
            2:       a = ($urandom_range(0, 9) < 6);
            default: a = (wait_cnt >= 3);
         endcase
         if (!mem_req) a = 1'b0;
         if (mem_req) begin
            exp_a = drop_pending ? drop_addr : exp_pc;
            chk("mem_addr", mem_addr, exp_a);
         end
         mem_ack   = a;
         mem_rdata = a ? (mem_addr ^ key) : $urandom;
         if (fl) begin
            if (mem_req && !a) begin
               if (!drop_pending) drop_addr = exp_pc;
               drop_pending = 1'b1;
            end else if (mem_req && a) begin
               drop_pending = 1'b0;
            end
            exp_pc = fa & 32'hFFFF_FFFC;
         end else if (mem_req && a) begin
            if (drop_pending) drop_pending = 1'b0;
            else begin
               exp_q.push_back('{exp_pc, exp_pc ^ key, cyc_now});
               exp_pc = exp_pc + 32'd4;
            end
         end
         wait_cnt  = (mem_req && !a) ? wait_cnt + 1 : 0;
         prev_req  = mem_req;
         prev_ack  = a;
         prev_addr = mem_addr;
      end
   endtask

   // decoder-side monitor: head must match the oldest word acked in an earlier cycle
   always @(negedge clk) begin
      bit vis;
      if (reset) begin
         chk("rst_mem_req", 32'(mem_req), 32'd0);
         chk("rst_mem_addr", mem_addr, RV);
         chk("rst_valid", 32'(instruction_valid), 32'd0);
         chk("rst_instr", instruction, 32'd0);
         chk("rst_pc", instruction_pc, 32'd0);
         exp_q.delete();
      end else begin
         vis = (exp_q.size() > 0) && (exp_q[0].cyc < cyc_now);
         chk("valid", 32'(instruction_valid), 32'(vis));
         if (vis && instruction_valid) begin
            chk("head_pc", instruction_pc, exp_q[0].pc);
            chk("head_instr", instruction, exp_q[0].data);
            if (decode_ready) begin
               popped_pcs.push_back(exp_q[0].pc);
               void'(exp_q.pop_front());
               pops++;
            end
         end
         if (flush) exp_q.delete();
         chk("occupancy", 32'(exp_q.size() <= DEPTH), 32'd1);
      end
   end

   initial begin
      int pops0;
      int n;
      reset        = 1'b1;
      decode_ready = 1'b0;
      flush        = 1'b0;
      flush_addr   = '0;
      mem_ack      = 1'b0;
      mem_rdata    = '0;

      repeat (3) step(1, 0, 0, 32'h0, 0);

      // zero-wait memory, address as data, decoder always ready
      step(0, 1, 0, 32'h0, 1);
      chk("first_req", 32'(mem_req), 32'd1);
      pops0 = pops;
      repeat (19) step(0, 1, 0, 32'h0, 1);
      @(negedge clk); #1;
      chk("zero_wait_rate", 32'(pops - pops0), 32'd19);

      // decoder stalled: queue fills to DEPTH and requests stop
      repeat (10) step(0, 0, 0, 32'h0, 1);
      chk("stall_req_low", 32'(mem_req), 32'd0);
      chk("stall_depth", 32'(exp_q.size()), 32'(DEPTH));
      repeat (8) step(0, 1, 0, 32'h0, 1);

      // slow memory
      key = $urandom;
      repeat (30) step(0, $urandom_range(0, 3) != 0, 0, 32'h0, 3);

      // flush while a request is outstanding, old word acked two cycles later
      n = 0;
      do begin
         step(0, 1, 0, 32'h0, 0);
         n++;
      end while (!mem_req && n < 10);
      chk("wait_req", 32'(mem_req), 32'd1);
      step(0, 1, 1, 32'h0000_0103, 0);
      step(0, 1, 0, 32'h0, 0);
      popped_pcs.delete();
      step(0, 1, 0, 32'h0, 1);
      step(0, 1, 0, 32'h0, 1);
      chk("post_flush_addr", mem_addr, 32'h0000_0100);
      repeat (3) step(0, 1, 0, 32'h0, 1);
      @(negedge clk); #1;
      chk("flush_first_pc", (popped_pcs.size() > 0) ? popped_pcs[0] : 32'hDEAD_BEEF,
          32'h0000_0100);

      // flush coinciding with ack and pop
      repeat (3) step(0, 1, 0, 32'h0, 1);
      step(0, 1, 1, 32'h0000_2000, 1);
      step(0, 1, 0, 32'h0, 1);
      chk("flush_ack_valid0", 32'(instruction_valid), 32'd0);
      chk("flush_ack_addr", mem_addr, 32'h0000_2000);
      repeat (3) step(0, 1, 0, 32'h0, 1);

      // address wrap at the top of memory
      step(0, 1, 1, 32'hFFFF_FFF8, 1);
      @(negedge clk); #1;
      popped_pcs.delete();
      repeat (6) step(0, 1, 0, 32'h0, 1);
      @(negedge clk); #1;
      chk("wrap_pc0", (popped_pcs.size() > 2) ? popped_pcs[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
      chk("wrap_pc1", (popped_pcs.size() > 2) ? popped_pcs[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
      chk("wrap_pc2", (popped_pcs.size() > 2) ? popped_pcs[2] : 32'hDEAD_BEEF, 32'h0000_0000);

      // reset mid-stream
      step(0, 0, 0, 32'h0, 0);
      step(1, 1, 0, 32'h0, 1);
      chk("midrst_req", 32'(mem_req), 32'd0);
      chk("midrst_valid", 32'(instruction_valid), 32'd0);
      step(1, 1, 0, 32'h0, 1);
      step(0, 1, 0, 32'h0, 1);
      chk("restart_req", 32'(mem_req), 32'd1);
      chk("restart_addr", mem_addr, RV);

      // randomized traffic with occasional flushes
      key = $urandom;
      repeat (600) step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0,
                        $urandom, 2);

      step(0, 1, 0, 32'h0, 1);
      @(negedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
